// File: rtl/bus_sram_target_pkg.sv
// Shared types and bus widths for the bus SRAM target.
// Imported by target_ram and bus_sram_target.
package bus_target_pkg;

    localparam int DATA_W  = 32;
    localparam int BE_W    = 4;
    localparam int BURST_W = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        WRITE = 3'd2,
        ERROR = 3'd3,
        END   = 3'd4
    } state_t;

endpackage

// File: rtl/bus_sram_target_ram.sv
// Single-port word RAM with per-byte write enables and one cycle read latency.
// A read of the word being written returns the old contents.
module target_ram
    import bus_target_pkg::*;
#(
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clock,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [BE_W-1:0]       byte_we,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);

    logic [DATA_W-1:0] mem_r [2**ADDR_WIDTH];

    // Byte-masked write and registered read of the addressed word.
    always_ff @(posedge clock) begin
        for (int i = 0; i < BE_W; i++) begin
            if (byte_we[i]) begin
                mem_r[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        rdata <= mem_r[addr];
    end

endmodule

// File: rtl/bus_sram_target.sv
// Memory-mapped bus target answering single/burst reads and writes into a RAM window.
// Optional macro BUS_SRAM_TARGET_WAIT_EN adds write wait states and read beat gaps.
module bus_sram_target
    import bus_target_pkg::*;
#(
    parameter logic [31:0] BASE_ADDRESS = 32'h5000_0000,
    parameter int          ADDR_WIDTH   = 9
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [DATA_W-1:0]  address_dataIN,
    input  logic [BE_W-1:0]    byte_enableIN,
    input  logic [BURST_W-1:0] burst_sizeIN,
    input  logic               read_n_writeIN,
    input  logic               begin_transactionIN,
    input  logic               end_transactionIN,
    input  logic               data_validIN,
    input  logic               busyIN,
    output logic [DATA_W-1:0]  address_dataOUT,
    output logic               end_transactionOUT,
    output logic               data_validOUT,
    output logic               busyOUT,
    output logic               errorOUT
);

    localparam int CNT_W = BURST_W + 1;
    localparam int SUM_W = ADDR_WIDTH + 9;
    localparam logic [SUM_W-1:0]      DEPTH     = {{(SUM_W-1){1'b0}}, 1'b1} << ADDR_WIDTH;
    localparam logic [CNT_W-1:0]      CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]      CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] IDX_ONE   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_t                 state_r, next_s;
    logic [ADDR_WIDTH-1:0]  idx_r;
    logic [BE_W-1:0]        be_r;
    logic [CNT_W-1:0]       left_r;
    logic [CNT_W-1:0]       pend_r;
    logic                   out_valid_r;
    logic [DATA_W-1:0]      out_data_r;
    logic                   end_out_r;
    logic                   err_out_r;

    logic [ADDR_WIDTH-1:0]  bus_idx_s;
    logic [SUM_W-1:0]       win_sum_s;
    logic                   hit_s;
    logic                   beat_done_s;
    logic                   last_beat_s;
    logic                   load_s;
    logic                   wr_accept_s;
    logic                   wr_en_s;
    logic                   busy_s;
    logic [ADDR_WIDTH-1:0]  ram_addr_s;
    logic [BE_W-1:0]        ram_we_s;
    logic [DATA_W-1:0]      ram_rdata_s;
    logic                   addr_unused_s;

    assign addr_unused_s = ^address_dataIN[1:0];

    // Window decode: high bits must match the aligned base, and the burst must end inside the RAM.
    always_comb begin
        bus_idx_s = address_dataIN[ADDR_WIDTH+1:2];
        win_sum_s = {{9{1'b0}}, bus_idx_s} + {{(ADDR_WIDTH+1){1'b0}}, burst_sizeIN};
        hit_s     = (address_dataIN[31:ADDR_WIDTH+2] == BASE_ADDRESS[31:ADDR_WIDTH+2])
                    && (win_sum_s < DEPTH);
    end

    // Beat handshakes; the output register is reloaded from RAM whenever it empties or drains.
    always_comb begin
        beat_done_s = out_valid_r & ~busyIN;
        last_beat_s = beat_done_s && (left_r == CNT_ONE);
        wr_accept_s = (state_r == WRITE) && data_validIN && !busy_s;
        wr_en_s     = wr_accept_s && (left_r != CNT_ZERO) && reset;
        if ((state_r == READ) && (pend_r != CNT_ZERO)) begin
`ifdef BUS_SRAM_TARGET_WAIT_EN
            load_s = !out_valid_r;
`else
            load_s = !out_valid_r || beat_done_s;
`endif
        end else begin
            load_s = 1'b0;
        end
    end

    // RAM address: bus index while idle so the first read word is ready one cycle after begin.
    always_comb begin
        ram_we_s = wr_en_s ? be_r : {BE_W{1'b0}};
        case (state_r)
            IDLE:    ram_addr_s = bus_idx_s;
            READ:    ram_addr_s = load_s ? (idx_r + IDX_ONE) : idx_r;
            default: ram_addr_s = idx_r;
        endcase
    end

    // Next-state logic.
    always_comb begin
        next_s = state_r;
        case (state_r)
            IDLE: begin
                if (begin_transactionIN) begin
                    if (!hit_s) begin
                        next_s = ERROR;
                    end else if (read_n_writeIN) begin
                        next_s = READ;
                    end else begin
                        next_s = WRITE;
                    end
                end else begin
                    next_s = IDLE;
                end
            end
            READ: begin
                if (end_transactionIN) begin
                    next_s = IDLE;
                end else if (last_beat_s) begin
                    next_s = END;
                end else begin
                    next_s = READ;
                end
            end
            WRITE: begin
                if (end_transactionIN) begin
                    next_s = IDLE;
                end else begin
                    next_s = WRITE;
                end
            end
            ERROR:   next_s = IDLE;
            END:     next_s = IDLE;
            default: next_s = IDLE;
        endcase
    end

    // State, transaction context and registered bus outputs.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r     <= IDLE;
            idx_r       <= {ADDR_WIDTH{1'b0}};
            be_r        <= {BE_W{1'b0}};
            left_r      <= CNT_ZERO;
            pend_r      <= CNT_ZERO;
            out_valid_r <= 1'b0;
            out_data_r  <= {DATA_W{1'b0}};
            end_out_r   <= 1'b0;
            err_out_r   <= 1'b0;
        end else begin
            state_r   <= next_s;
            end_out_r <= (next_s == ERROR) || (next_s == END);
            err_out_r <= (next_s == ERROR);
            case (state_r)
                IDLE: begin
                    if (begin_transactionIN) begin
                        idx_r  <= bus_idx_s;
                        be_r   <= byte_enableIN;
                        left_r <= {1'b0, burst_sizeIN} + CNT_ONE;
                        pend_r <= {1'b0, burst_sizeIN} + CNT_ONE;
                    end
                end
                READ: begin
                    if (end_transactionIN) begin
                        out_valid_r <= 1'b0;
                        out_data_r  <= {DATA_W{1'b0}};
                    end else begin
                        if (load_s) begin
                            out_valid_r <= 1'b1;
                            out_data_r  <= ram_rdata_s;
                            idx_r       <= idx_r + IDX_ONE;
                            pend_r      <= pend_r - CNT_ONE;
                        end else if (beat_done_s) begin
                            out_valid_r <= 1'b0;
                            out_data_r  <= {DATA_W{1'b0}};
                        end
                        if (beat_done_s) begin
                            left_r <= left_r - CNT_ONE;
                        end
                    end
                end
                WRITE: begin
                    if (wr_en_s) begin
                        idx_r  <= idx_r + IDX_ONE;
                        left_r <= left_r - CNT_ONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef BUS_SRAM_TARGET_WAIT_EN
    logic busy_r;

    // One stall cycle after every accepted write beat.
    always_ff @(posedge clock) begin
        if (!reset) begin
            busy_r <= 1'b0;
        end else begin
            busy_r <= wr_accept_s && !end_transactionIN;
        end
    end

    assign busy_s = busy_r;
`else
    assign busy_s = 1'b0;
`endif

    target_ram #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clock   (clock),
        .addr    (ram_addr_s),
        .byte_we (ram_we_s),
        .wdata   (address_dataIN),
        .rdata   (ram_rdata_s)
    );

    assign address_dataOUT    = out_data_r;
    assign data_validOUT      = out_valid_r;
    assign end_transactionOUT = end_out_r;
    assign errorOUT           = err_out_r;
    assign busyOUT            = busy_s;

endmodule

// File: tb/tb_bus_sram_target.sv
// Directed bench for bus_sram_target; follows BUS_SRAM_TARGET_WAIT_EN for beat spacing.
module tb_bus_sram_target;

`ifdef BUS_SRAM_TARGET_WAIT_EN
    localparam int GAP = 2;
    localparam logic WAIT_BUSY = 1'b1;
`else
    localparam int GAP = 1;
    localparam logic WAIT_BUSY = 1'b0;
`endif

    logic        clock;
    logic        reset;
    logic [31:0] a_in;
    logic [3:0]  be_in;
    logic [7:0]  burst_in;
    logic        rnw_in;
    logic        begin_in;
    logic        end_in;
    logic        dv_in;
    logic        busy_in;
    logic [31:0] d_out;
    logic        end_out;
    logic        dv_out;
    logic        busy_out;
    logic        err_out;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int first_cyc = 0;
    int last_cyc = 0;
    logic [31:0] rd_q[$];

    bus_sram_target dut (
        .clock               (clock),
        .reset               (reset),
        .address_dataIN      (a_in),
        .byte_enableIN       (be_in),
        .burst_sizeIN        (burst_in),
        .read_n_writeIN      (rnw_in),
        .begin_transactionIN (begin_in),
        .end_transactionIN   (end_in),
        .data_validIN        (dv_in),
        .busyIN              (busy_in),
        .address_dataOUT     (d_out),
        .end_transactionOUT  (end_out),
        .data_validOUT       (dv_out),
        .busyOUT             (busy_out),
        .errorOUT            (err_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (busy_out === 1'b1 && n < 8) begin
            step();
            n++;
        end
        check("write_ready", {31'd0, busy_out}, 32'd0);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [3:0] be, input logic [7:0] burst,
                            input logic [31:0] d0, input int n);
        a_in = addr; be_in = be; burst_in = burst; rnw_in = 1'b0; begin_in = 1'b1;
        step();
        begin_in = 1'b0;
        for (int i = 0; i < n; i++) begin
            dv_in = 1'b1;
            a_in  = d0 + 32'(i);
            wait_ready();
            if (i == n - 1) end_in = 1'b1;
            step();
        end
        dv_in = 1'b0; end_in = 1'b0; a_in = 32'd0;
        step();
    endtask

    task automatic collect();
        int n = 0;
        bit done = 1'b0;
        rd_q.delete();
        while (!done && n < 40) begin
            if (dv_out && !busy_in) begin
                rd_q.push_back(d_out);
                if (rd_q.size() == 1) first_cyc = cyc;
                last_cyc = cyc;
            end
            if (end_out) begin
                done = 1'b1;
            end else begin
                step();
                n++;
            end
        end
        check("read_end_seen", {31'd0, done}, 32'd1);
        step();
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [7:0] burst);
        a_in = addr; burst_in = burst; rnw_in = 1'b1; be_in = 4'hF; begin_in = 1'b1;
        step();
        begin_in = 1'b0; a_in = 32'd0;
        collect();
    endtask

    initial begin
        reset = 1'b0; a_in = 32'd0; be_in = 4'h0; burst_in = 8'd0; rnw_in = 1'b0;
        begin_in = 1'b0; end_in = 1'b0; dv_in = 1'b0; busy_in = 1'b0;
        step(); step(); step();
        check("reset_dv", {31'd0, dv_out}, 32'd0);
        check("reset_end", {31'd0, end_out}, 32'd0);
        check("reset_err", {31'd0, err_out}, 32'd0);
        check("reset_busy", {31'd0, busy_out}, 32'd0);
        check("reset_data", d_out, 32'd0);
        reset = 1'b1;
        step();

        // Single read latency: valid at cycle 2, end at cycle 3.
        do_write(32'h5000_000C, 4'hF, 8'd0, 32'hDEAD_BEEF, 1);
        a_in = 32'h5000_000C; burst_in = 8'd0; rnw_in = 1'b1; begin_in = 1'b1;
        step();
        begin_in = 1'b0; a_in = 32'd0;
        check("single_c1_dv", {31'd0, dv_out}, 32'd0);
        step();
        check("single_c2_dv", {31'd0, dv_out}, 32'd1);
        check("single_c2_data", d_out, 32'hDEAD_BEEF);
        check("single_c2_end", {31'd0, end_out}, 32'd0);
        step();
        check("single_c3_end", {31'd0, end_out}, 32'd1);
        check("single_c3_dv", {31'd0, dv_out}, 32'd0);
        check("single_c3_data", d_out, 32'd0);
        step();
        check("single_c4_end", {31'd0, end_out}, 32'd0);

        // Burst write 1..4 then burst read.
        do_write(32'h5000_0000, 4'hF, 8'd3, 32'd1, 4);
        do_read(32'h5000_0000, 8'd3);
        check("burst_count", 32'(rd_q.size()), 32'd4);
        for (int i = 0; i < 4; i++) check("burst_data", rd_q[i], 32'(i + 1));
        check("burst_span", 32'(last_cyc - first_cyc), 32'(3 * GAP));

        // Byte enables.
        do_write(32'h5000_0000, 4'hF, 8'd0, 32'h1122_3344, 1);
        do_write(32'h5000_0000, 4'b0101, 8'd0, 32'hAABB_CCDD, 1);
        do_read(32'h5000_0000, 8'd0);
        check("be_count", 32'(rd_q.size()), 32'd1);
        check("be_data", rd_q[0], 32'h11BB_33DD);

        // Stall on the first read beat for three cycles.
        a_in = 32'h5000_0000; burst_in = 8'd1; rnw_in = 1'b1; begin_in = 1'b1;
        step();
        begin_in = 1'b0; a_in = 32'd0;
        step();
        busy_in = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check("stall_dv", {31'd0, dv_out}, 32'd1);
            check("stall_data", d_out, 32'h11BB_33DD);
            step();
        end
        check("stall_release_dv", {31'd0, dv_out}, 32'd1);
        busy_in = 1'b0;
        collect();
        check("stall_count", 32'(rd_q.size()), 32'd2);
        check("stall_beat0", rd_q[0], 32'h11BB_33DD);
        check("stall_beat1", rd_q[1], 32'd2);

        // Window errors: burst past the last word, then an address outside the window.
        do_write(32'h5000_07FC, 4'hF, 8'd0, 32'hCAFE_0001, 1);
        a_in = 32'h5000_07FC; burst_in = 8'd1; rnw_in = 1'b0; be_in = 4'hF; begin_in = 1'b1;
        step();
        begin_in = 1'b0; dv_in = 1'b1; a_in = 32'h0000_0BAD;
        check("err1_err", {31'd0, err_out}, 32'd1);
        check("err1_end", {31'd0, end_out}, 32'd1);
        step();
        dv_in = 1'b0; a_in = 32'd0;
        check("err1_err_clear", {31'd0, err_out}, 32'd0);
        check("err1_end_clear", {31'd0, end_out}, 32'd0);
        a_in = 32'h4000_0000; burst_in = 8'd0; rnw_in = 1'b1; begin_in = 1'b1;
        step();
        begin_in = 1'b0; a_in = 32'd0;
        check("err2_err", {31'd0, err_out}, 32'd1);
        check("err2_end", {31'd0, end_out}, 32'd1);
        check("err2_dv", {31'd0, dv_out}, 32'd0);
        step();
        check("err2_err_clear", {31'd0, err_out}, 32'd0);
        do_read(32'h5000_07FC, 8'd0);
        check("err_ram_kept", rd_q[0], 32'hCAFE_0001);

        // Reset during the third beat of a four-beat write.
        a_in = 32'h5000_0000; burst_in = 8'd3; rnw_in = 1'b0; be_in = 4'hF; begin_in = 1'b1;
        step();
        begin_in = 1'b0;
        for (int i = 0; i < 2; i++) begin
            dv_in = 1'b1;
            a_in  = 32'h0000_00A0 + 32'(i);
            wait_ready();
            step();
        end
        dv_in = 1'b1; a_in = 32'h0000_00A2;
        wait_ready();
        reset = 1'b0;
        step();
        check("rst_dv", {31'd0, dv_out}, 32'd0);
        check("rst_busy", {31'd0, busy_out}, 32'd0);
        check("rst_end", {31'd0, end_out}, 32'd0);
        reset = 1'b1; dv_in = 1'b0; a_in = 32'd0;
        step();
        do_read(32'h5000_0000, 8'd3);
        check("rst_count", 32'(rd_q.size()), 32'd4);
        check("rst_w0", rd_q[0], 32'h0000_00A0);
        check("rst_w1", rd_q[1], 32'h0000_00A1);
        check("rst_w2", rd_q[2], 32'd3);
        check("rst_w3", rd_q[3], 32'd4);

        // Abort a read, then start a new one.
        a_in = 32'h5000_0000; burst_in = 8'd3; rnw_in = 1'b1; begin_in = 1'b1;
        step();
        begin_in = 1'b0; a_in = 32'd0;
        step();
        check("abort_dv_before", {31'd0, dv_out}, 32'd1);
        end_in = 1'b1;
        step();
        end_in = 1'b0;
        check("abort_dv", {31'd0, dv_out}, 32'd0);
        check("abort_data", d_out, 32'd0);
        check("abort_end", {31'd0, end_out}, 32'd0);
        do_read(32'h5000_000C, 8'd0);
        check("abort_next_count", 32'(rd_q.size()), 32'd1);
        check("abort_next_data", rd_q[0], 32'd4);

        // Write-beat wait state, then a beat beyond the latched count.
        a_in = 32'h5000_0018; burst_in = 8'd0; rnw_in = 1'b0; be_in = 4'hF; begin_in = 1'b1;
        step();
        begin_in = 1'b0; dv_in = 1'b1; a_in = 32'h0000_0066;
        check("wait_pre_busy", {31'd0, busy_out}, 32'd0);
        step();
        dv_in = 1'b0; end_in = 1'b1; a_in = 32'd0;
        check("wait_busy", {31'd0, busy_out}, {31'd0, WAIT_BUSY});
        step();
        end_in = 1'b0;
        check("wait_busy_clear", {31'd0, busy_out}, 32'd0);
        do_write(32'h5000_0014, 4'hF, 8'd0, 32'h0000_0055, 2);
        do_read(32'h5000_0014, 8'd1);
        check("extra_count", 32'(rd_q.size()), 32'd2);
        check("extra_w5", rd_q[0], 32'h0000_0055);
        check("extra_w6", rd_q[1], 32'h0000_0066);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
